// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the expression evaluator.
package expr_pkg;

    typedef enum logic [2:0] {
        S_START,
        S_DIGIT,
        S_OP,
        S_ERR,
        S_DONE
    } state_e;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier for the expression grammar.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] in_char,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_mul,
    output logic       is_eq,
    output logic       is_bad,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = (in_char >= CH_0) && (in_char <= CH_9);
        is_mul   = (in_char == CH_MUL);
        is_op    = is_mul || (in_char == CH_PLUS);
        is_eq    = (in_char == CH_EQ);
        is_bad   = !(is_digit || is_op || is_eq);
        digit    = is_digit ? 4'(in_char - CH_0) : 4'd0;
    end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for digit ((+|*) digit)* '=' with '*' over '+'.
module expr_eval_ctrl
    import expr_pkg::*;
#(
    parameter int W       = 8,
    parameter int MAX_LEN = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_char,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_ok,
    output logic         res_ovf,
    output logic [W-1:0] res_value,
    output logic         busy
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    logic         is_digit;
    logic         is_op;
    logic         is_mul;
    logic         is_eq;
    logic         is_bad;
    logic         is_plus;
    logic [3:0]   digit;

    state_e       state_q;
    logic [W-1:0] sum_q;
    logic [W-1:0] term_q;
    logic         mul_pend_q;
    logic [LW-1:0] len_q;
    logic         err_q;
    logic         ovf_q;
    logic         in_ready_q;
    logic         res_valid_q;
    logic         res_ok_q;
    logic         res_ovf_q;
    logic [W-1:0] res_value_q;
    logic         busy_q;

    logic         accept;
    logic [W:0]   sum_d;
    logic [W+3:0] prod_d;
    logic         prod_ovf;
    logic         fin_ok;

    expr_char_class u_cls (
        .in_char  (in_char),
        .is_digit (is_digit),
        .is_op    (is_op),
        .is_mul   (is_mul),
        .is_eq    (is_eq),
        .is_bad   (is_bad),
        .digit    (digit)
    );

    // sum_d doubles as the '+' update and the final result; bit W is the carry.
    assign is_plus  = is_op & ~is_mul;
    assign accept   = in_valid & in_ready_q;
    assign sum_d    = {1'b0, sum_q} + {1'b0, term_q};
    assign prod_d   = {4'b0, term_q} * {{W{1'b0}}, digit};
    assign prod_ovf = |prod_d[W+3:W];
    assign fin_ok   = ~err_q & (state_q == S_DIGIT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_START;
            sum_q       <= '0;
            term_q      <= '0;
            mul_pend_q  <= 1'b0;
            len_q       <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_ok_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_value_q <= '0;
            busy_q      <= 1'b0;
        end else if (state_q == S_DONE) begin
            if (res_ready) begin
                state_q     <= S_START;
                sum_q       <= '0;
                term_q      <= '0;
                mul_pend_q  <= 1'b0;
                len_q       <= '0;
                err_q       <= 1'b0;
                ovf_q       <= 1'b0;
                in_ready_q  <= 1'b1;
                res_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end
        end else if (accept) begin
            busy_q <= 1'b1;
            if (is_eq) begin
                state_q     <= S_DONE;
                in_ready_q  <= 1'b0;
                res_valid_q <= 1'b1;
                res_ok_q    <= fin_ok;
                res_value_q <= fin_ok ? sum_d[W-1:0] : '0;
                res_ovf_q   <= fin_ok & (ovf_q | sum_d[W]);
                if (state_q == S_OP) err_q <= 1'b1;
            end else begin
                if (len_q == LEN_MAX) err_q <= 1'b1;
                else len_q <= len_q + LW'(1);
                unique case (state_q)
                    S_START: begin
                        unique case (1'b1)
                            is_digit: begin
                                term_q  <= W'(digit);
                                state_q <= S_DIGIT;
                            end
                            is_op, is_bad: begin
                                err_q   <= 1'b1;
                                state_q <= S_ERR;
                            end
                        endcase
                    end
                    S_DIGIT: begin
                        unique case (1'b1)
                            is_plus: begin
                                sum_q   <= sum_d[W-1:0];
                                if (sum_d[W]) ovf_q <= 1'b1;
                                state_q <= S_OP;
                            end
                            is_mul: begin
                                mul_pend_q <= 1'b1;
                                state_q    <= S_OP;
                            end
                            is_digit, is_bad: begin
                                err_q   <= 1'b1;
                                state_q <= S_ERR;
                            end
                        endcase
                    end
                    S_OP: begin
                        unique case (1'b1)
                            is_digit: begin
                                term_q     <= mul_pend_q ? prod_d[W-1:0] : W'(digit);
                                if (mul_pend_q && prod_ovf) ovf_q <= 1'b1;
                                mul_pend_q <= 1'b0;
                                state_q    <= S_DIGIT;
                            end
                            is_op, is_bad: begin
                                err_q   <= 1'b1;
                                state_q <= S_ERR;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_ok    = res_ok_q;
    assign res_ovf   = res_ovf_q;
    assign res_value = res_value_q;
    assign busy      = busy_q;

endmodule
